imem_arbiter: RTL and testbench

- Arbitrates the single-port synchronous instruction memory between two requesters: the CPU fetch port and the program-loader/debug port.
- Provides request/grant handshakes, routes 1-cycle-latency read data back to the owner, converts byte addresses to word addresses, and returns NOP/error for bad addresses.
- Sits between the fetch stage / loader and the instruction RAM.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_addr_chk.sv | 18 +
 rtl/imem_arbiter.sv | 142 ++++++++++++++
 tb/tb_imem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   owner_e  : which requester owns the response slot next cycle
//   state_e  : loader lock state
//   NOP_WORD : data returned on an error response (MIPS NOP)
//   addr_ok  : byte-address alignment and range check
package imem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // A byte address is usable when it is word aligned and every bit above
    // the memory's word-address field is zero.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_addr_chk.sv
// Alignment/range check and word-address extraction for one byte address.
//   addr      in  32      byte address of the granted request
//   ok        out 1       address is aligned and inside the memory
//   word_addr out ADDR_W  memory word address
module imem_addr_chk
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [31:0]       addr,
    output logic              ok,
    output logic [ADDR_W-1:0] word_addr
);

    assign ok        = addr_ok(addr, ADDR_W);
    assign word_addr = addr[ADDR_W+1:2];

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a single-port synchronous instruction RAM between the CPU fetch
// port (read only) and the loader/debug port (read/write, optional lock).
//   clk, rst                  clock, synchronous active-high reset
//   f_req/f_addr/f_gnt        fetch request handshake (byte address)
//   f_rvalid/f_rdata/f_err    fetch response, one cycle after grant
//   l_req/l_we/l_lock/l_addr/l_wdata/l_gnt   loader request handshake
//   l_rvalid/l_rdata/l_err    loader response / write ack
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port (1-cycle read)
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned FETCH_RUN_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned RUN_W = $clog2(FETCH_RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FETCH_RUN_MAX);

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    owner_e           own_q, own_d;
    logic             rerr_q, rerr_d;
    logic             rwr_q, rwr_d;

    logic [31:0]       win_addr;
    logic              win_ok;
    logic [ADDR_W-1:0] win_word;
    logic              any_gnt;

    // Grant: all grants are forced low while rst is high.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                l_gnt = l_req;
            end else if (f_req && l_req && (run_q == RUN_MAX)) begin
                l_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end else begin
                l_gnt = l_req;
            end
        end
    end

    assign any_gnt  = f_gnt | l_gnt;
    assign win_addr = l_gnt ? l_addr : f_addr;

    imem_addr_chk #(
        .ADDR_W (ADDR_W)
    ) u_addr_chk (
        .addr      (win_addr),
        .ok        (win_ok),
        .word_addr (win_word)
    );

    assign mem_en    = any_gnt & win_ok;
    assign mem_we    = mem_en & l_gnt & l_we;
    assign mem_addr  = mem_en ? win_word : '0;
    assign mem_wdata = mem_we ? l_wdata : '0;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        own_d   = OWN_NONE;
        rerr_d  = 1'b0;
        rwr_d   = 1'b0;

        // A locked loader holds ownership even while idle; release is seen
        // one cycle late, so a grant in the release cycle still goes through.
        case (state_q)
            ST_NORMAL: if (l_gnt && l_lock) state_d = ST_LOCKED;
            ST_LOCKED: if (!l_lock) state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase

        if (l_gnt || !l_req) begin
            run_d = '0;
        end else if (f_gnt && (run_q != RUN_MAX)) begin
            run_d = run_q + 1'b1;
        end

        if (f_gnt) begin
            own_d = OWN_FETCH;
        end else if (l_gnt) begin
            own_d = OWN_LOADER;
        end
        rerr_d = any_gnt & ~win_ok;
        rwr_d  = l_gnt & l_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            run_q   <= '0;
            own_q   <= OWN_NONE;
            rerr_q  <= 1'b0;
            rwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            own_q   <= own_d;
            rerr_q  <= rerr_d;
            rwr_q   <= rwr_d;
        end
    end

    // Responses are gated by rst so a grant from the cycle before reset is
    // dropped rather than answered during the reset cycle.
    assign f_rvalid = ~rst & (own_q == OWN_FETCH);
    assign f_err    = f_rvalid & rerr_q;
    assign f_rdata  = (f_rvalid && !rerr_q) ? mem_rdata : NOP_WORD;

    assign l_rvalid = ~rst & (own_q == OWN_LOADER);
    assign l_err    = l_rvalid & rerr_q;
    assign l_rdata  = (l_rvalid && !rerr_q && !rwr_q) ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: a behavioural RAM answers the memory
// port, expected responses are queued when a grant is expected and checked
// by a response monitor one cycle later.
module tb_imem_arbiter;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req, l_req, l_we, l_lock;
    logic [31:0]       f_addr, l_addr, l_wdata;
    logic              f_gnt, f_rvalid, f_err;
    logic [31:0]       f_rdata;
    logic              l_gnt, l_rvalid, l_err;
    logic [31:0]       l_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;

    typedef struct {
        bit          ldr;
        bit          err;
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    imem_arbiter #(
        .ADDR_W        (ADDR_W),
        .FETCH_RUN_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_lock    (l_lock),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .l_err     (l_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Response monitor: every cycle the response ports must match either the
    // entry due this cycle or all-zero.
    always @(negedge clk) begin
        logic [67:0] obs, want;
        exp_t e;
        obs  = {f_rvalid, f_err, f_rdata, l_rvalid, l_err, l_rdata};
        want = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            want = e.ldr ? {2'b00, 32'h0, 1'b1, e.err, e.data}
                         : {1'b1, e.err, e.data, 2'b00, 32'h0};
        end
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL rsp cyc=%0d got {fv,fe,fd,lv,le,ld}=%h want %h", cyc, obs, want);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic expect_rsp(input bit ldr, input bit err, input logic [31:0] d);
        sb.push_back('{ldr: ldr, err: err, data: d, due: cyc + 1});
    endtask

    task automatic test_reset();
        rst = 1; f_req = 1; l_req = 1; l_addr = 32'h4; l_wdata = 32'h1234_5678; l_we = 1;
        @(negedge clk);
        vectors++;
        if ({f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b %h %h want all zero",
                     f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_fetch_only();
        logic [31:0] words [3];
        words[0] = 32'h2008_0005; words[1] = 32'h2009_0003; words[2] = 32'h0109_5020;
        for (int i = 0; i < 3; i++) begin
            f_req = 1; f_addr = 32'(i * 4);
            @(negedge clk);
            vectors++;
            if ({f_gnt, l_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 16'(i)}) begin
                errors++;
                $display("FAIL fetch_gnt[%0d] got g=%b%b en=%b we=%b a=%h want 1010 a=%h",
                         i, f_gnt, l_gnt, mem_en, mem_we, mem_addr, 16'(i));
            end
            expect_rsp(0, 0, words[i]);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fairness();
        bit want_l;
        f_req = 1; l_req = 1; l_we = 0; l_lock = 0; f_addr = 32'h0; l_addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            want_l = (i == 4) || (i == 9);
            @(negedge clk);
            vectors++;
            if ({f_gnt, l_gnt} !== {!want_l, want_l}) begin
                errors++;
                $display("FAIL fair_cycle%0d got f_gnt=%b l_gnt=%b want %b %b",
                         i, f_gnt, l_gnt, !want_l, want_l);
            end
            if (want_l) expect_rsp(1, 0, 32'h2009_0003);
            else        expect_rsp(0, 0, 32'h2008_0005);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        l_req = 1; l_we = 1; l_lock = 1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++;
        if ({l_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'h4, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL lock_write got g=%b en=%b we=%b a=%h d=%h", l_gnt, mem_en, mem_we,
                     mem_addr, mem_wdata);
        end
        expect_rsp(1, 0, 32'h0);
        tick();
        l_req = 0; l_we = 0; f_req = 1; f_addr = 32'h10;
        // three idle cycles still locked, then the release cycle itself
        for (int i = 0; i < 4; i++) begin
            if (i == 3) l_lock = 0;
            @(negedge clk);
            vectors++;
            if ({f_gnt, l_gnt, mem_en} !== 3'b000) begin
                errors++;
                $display("FAIL lock_hold%0d got f_gnt=%b l_gnt=%b mem_en=%b want 000",
                         i, f_gnt, l_gnt, mem_en);
            end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_release got f_gnt=%b want 1", f_gnt);
        end
        expect_rsp(0, 0, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_release_with_request();
        l_req = 1; l_lock = 1; l_addr = 32'h0;
        @(negedge clk);
        expect_rsp(1, 0, 32'h2008_0005);
        tick();
        l_lock = 0; l_addr = 32'h4; f_req = 1; f_addr = 32'h8;
        @(negedge clk);
        vectors++;
        if ({f_gnt, l_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rel_same_cycle got f_gnt=%b l_gnt=%b want 0 1", f_gnt, l_gnt);
        end
        expect_rsp(1, 0, 32'h2009_0003);
        tick();
        l_req = 0;
        @(negedge clk);
        vectors++;
        if ({f_gnt, l_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rel_next_fetch got f_gnt=%b l_gnt=%b want 1 0", f_gnt, l_gnt);
        end
        expect_rsp(0, 0, 32'h0109_5020);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] bad_f [2];
        bad_f[0] = 32'h6; bad_f[1] = 32'h0004_0000;
        for (int i = 0; i < 2; i++) begin
            f_req = 1; f_addr = bad_f[i];
            @(negedge clk);
            vectors++;
            if ({f_gnt, mem_en, mem_we} !== 3'b100) begin
                errors++;
                $display("FAIL err_fetch%0d got f_gnt=%b mem_en=%b mem_we=%b want 100",
                         i, f_gnt, mem_en, mem_we);
            end
            expect_rsp(0, 1, 32'h0);
            tick();
        end
        f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h0004_0000; l_wdata = 32'hBAD0_BAD0;
        @(negedge clk);
        vectors++;
        if ({l_gnt, mem_en, mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL err_ldr_wr got l_gnt=%b mem_en=%b mem_we=%b want 100",
                     l_gnt, mem_en, mem_we);
        end
        expect_rsp(1, 1, 32'h0);
        tick();
        l_we = 0; l_addr = 32'h2;
        @(negedge clk);
        expect_rsp(1, 1, 32'h0);
        tick();
        // word 0 must be untouched by the rejected write
        l_req = 0; f_req = 1; f_addr = 32'h0;
        @(negedge clk);
        expect_rsp(0, 0, 32'h2008_0005);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        bit want_l;
        f_req = 1; l_req = 1; f_addr = 32'h0; l_addr = 32'h8;
        @(negedge clk);
        expect_rsp(0, 0, 32'h2008_0005);
        tick();
        @(negedge clk);
        vectors++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_gnt got f_gnt=%b want 1", f_gnt);
        end
        tick();
        rst = 1;
        @(negedge clk);
        vectors++;
        if ({f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got g=%b%b rv=%b%b en=%b want 00000",
                     f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en);
        end
        tick();
        rst = 0;
        // counter must restart from zero: loader wins only on the fifth cycle
        for (int i = 0; i < 5; i++) begin
            want_l = (i == 4);
            @(negedge clk);
            vectors++;
            if ({f_gnt, l_gnt} !== {!want_l, want_l}) begin
                errors++;
                $display("FAIL rstmid_run%0d got f_gnt=%b l_gnt=%b want %b %b",
                         i, f_gnt, l_gnt, !want_l, want_l);
            end
            if (want_l) expect_rsp(1, 0, 32'h0109_5020);
            else        expect_rsp(0, 0, 32'h2008_0005);
            tick();
        end
        idle_inputs();
        // take the lock, then reset while it is held
        l_req = 1; l_lock = 1; l_addr = 32'h4;
        @(negedge clk);
        expect_rsp(1, 0, 32'h2009_0003);
        tick();
        l_req = 0;
        tick();
        rst = 1;
        tick();
        rst = 0; f_req = 1; f_addr = 32'h8;
        @(negedge clk);
        vectors++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_lock_released got f_gnt=%b want 1", f_gnt);
        end
        expect_rsp(0, 0, 32'h0109_5020);
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        ram[0] = 32'h2008_0005;
        ram[1] = 32'h2009_0003;
        ram[2] = 32'h0109_5020;
        mem_rdata = '0;
        rst = 1;
        idle_inputs();
        tick();
        test_reset();
        test_fetch_only();
        test_fairness();
        test_lock();
        test_release_with_request();
        test_errors();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending responses want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
